// File: rtl/rf_path_sequencer.sv
// rf_path_sequencer: break-before-make sequencing of the RF front-end pins
// between rf_modes, with a valid/ready request port and a forced low-power
// override that aborts any sequence in progress.
module rf_path_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned LNA_ON_CYCLES = 32
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic       i_req_valid,
  input  logic [2:0] i_req_mode,
  output logic       o_req_ready,
  input  logic       i_force_lp,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [2:0] o_cur_mode,
  output logic       o_mixer_en,
  output logic       o_shdn_rx_lna,
  output logic       o_shdn_tx_lna,
  output logic       o_tr_vc1,
  output logic       o_tr_vc1_b,
  output logic       o_tr_vc2,
  output logic       o_rx_h_tx_l,
  output logic       o_rx_h_tx_l_b
);

  localparam int unsigned MODE_W     = 3;
  localparam int unsigned LNA_W      = 3;
  localparam int unsigned SW_W       = 5;
  localparam int unsigned PAT_W      = LNA_W + SW_W;
  localparam int unsigned MAX_CYCLES = (SETTLE_CYCLES > LNA_ON_CYCLES) ? SETTLE_CYCLES : LNA_ON_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LNA_ON_LOAD = CNT_W'(LNA_ON_CYCLES - 1);
  localparam logic [LNA_W-1:0]  LNA_SHDN    = 3'b011;
  localparam logic [MODE_W-1:0] MODE_LP     = 3'b000;
  localparam logic [MODE_W-1:0] MODE_MAX    = 3'b101;
  localparam logic [PAT_W-1:0]  PAT_LP      = 8'h69;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GUARD_OFF = 2'd1,
    ST_GUARD_ON  = 2'd2
  } state_t;

  // Pin pattern per mode: {mixer, shdn_rx, shdn_tx, vc1, vc1_b, vc2, rx_h, rx_h_b}
  function automatic logic [PAT_W-1:0] mode_pattern(input logic [MODE_W-1:0] mode);
    case (mode)
      3'b000:  mode_pattern = 8'h69;
      3'b001:  mode_pattern = 8'h71;
      3'b010:  mode_pattern = 8'hAE;
      3'b011:  mode_pattern = 8'hAD;
      3'b100:  mode_pattern = 8'hD5;
      3'b101:  mode_pattern = 8'hD6;
      default: mode_pattern = PAT_LP;
    endcase
  endfunction

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [MODE_W-1:0]  target_q, target_n;
  logic [MODE_W-1:0]  cur_mode_q, cur_mode_n;
  logic               forced_q, forced_n;
  logic [LNA_W-1:0]   lna_q, lna_n;
  logic [SW_W-1:0]    sw_q, sw_n;
  logic               done_q, done_n;
  logic               err_q, err_n;
  logic               busy_q, busy_n;
  logic [PAT_W-1:0]   tgt_pat;
  logic               force_start;
  logic               req_accept;

  // Handshake qualifiers: force wins over a same-cycle request
  assign o_req_ready = (state_q == ST_IDLE) && !i_force_lp;
  assign req_accept  = i_req_valid && o_req_ready;
  assign force_start = i_force_lp && !forced_q &&
                       !((state_q == ST_IDLE) && (cur_mode_q == MODE_LP));

  // Next-state and next-output computation
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    target_n   = target_q;
    cur_mode_n = cur_mode_q;
    forced_n   = forced_q;
    lna_n      = lna_q;
    sw_n       = sw_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    tgt_pat    = mode_pattern(target_q);

    if (force_start) begin
      lna_n    = LNA_SHDN;
      target_n = MODE_LP;
      cnt_n    = SETTLE_LOAD;
      forced_n = 1'b1;
      state_n  = ST_GUARD_OFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_accept) begin
            if (i_req_mode > MODE_MAX) begin
              err_n = 1'b1;
            end else if (i_req_mode == cur_mode_q) begin
              done_n = 1'b1;
            end else begin
              lna_n    = LNA_SHDN;
              target_n = i_req_mode;
              cnt_n    = SETTLE_LOAD;
              forced_n = 1'b0;
              state_n  = ST_GUARD_OFF;
            end
          end
        end
        ST_GUARD_OFF: begin
          if (cnt_q == '0) begin
            sw_n    = tgt_pat[SW_W-1:0];
            cnt_n   = LNA_ON_LOAD;
            state_n = ST_GUARD_ON;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        ST_GUARD_ON: begin
          if (cnt_q == '0) begin
            lna_n      = tgt_pat[PAT_W-1:SW_W];
            cur_mode_n = target_q;
            done_n     = 1'b1;
            forced_n   = 1'b0;
            state_n    = ST_IDLE;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= MODE_LP;
      cur_mode_q <= MODE_LP;
      forced_q   <= 1'b0;
      lna_q      <= PAT_LP[PAT_W-1:SW_W];
      sw_q       <= PAT_LP[SW_W-1:0];
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      target_q   <= target_n;
      cur_mode_q <= cur_mode_n;
      forced_q   <= forced_n;
      lna_q      <= lna_n;
      sw_q       <= sw_n;
      done_q     <= done_n;
      err_q      <= err_n;
      busy_q     <= busy_n;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_cur_mode    = cur_mode_q;
  assign o_mixer_en    = lna_q[2];
  assign o_shdn_rx_lna = lna_q[1];
  assign o_shdn_tx_lna = lna_q[0];
  assign o_tr_vc1      = sw_q[4];
  assign o_tr_vc1_b    = sw_q[3];
  assign o_tr_vc2      = sw_q[2];
  assign o_rx_h_tx_l   = sw_q[1];
  assign o_rx_h_tx_l_b = sw_q[0];

endmodule

// File: tb/tb_rf_path_sequencer.sv
// tb_rf_path_sequencer: directed and random stimulus checked against an
// elapsed-time reference model of the mode-change timeline.
module tb_rf_path_sequencer;

  localparam int unsigned S = 4;
  localparam int unsigned L = 2;

  logic       i_sys_clk = 1'b0;
  logic       i_rst_b;
  logic       i_req_valid;
  logic [2:0] i_req_mode;
  logic       i_force_lp;
  logic       o_req_ready, o_busy, o_done, o_err;
  logic [2:0] o_cur_mode;
  logic       o_mixer_en, o_shdn_rx_lna, o_shdn_tx_lna;
  logic       o_tr_vc1, o_tr_vc1_b, o_tr_vc2, o_rx_h_tx_l, o_rx_h_tx_l_b;
  logic [7:0] pins;

  rf_path_sequencer #(.SETTLE_CYCLES(S), .LNA_ON_CYCLES(L)) dut (
    .i_sys_clk     (i_sys_clk),
    .i_rst_b       (i_rst_b),
    .i_req_valid   (i_req_valid),
    .i_req_mode    (i_req_mode),
    .o_req_ready   (o_req_ready),
    .i_force_lp    (i_force_lp),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_cur_mode    (o_cur_mode),
    .o_mixer_en    (o_mixer_en),
    .o_shdn_rx_lna (o_shdn_rx_lna),
    .o_shdn_tx_lna (o_shdn_tx_lna),
    .o_tr_vc1      (o_tr_vc1),
    .o_tr_vc1_b    (o_tr_vc1_b),
    .o_tr_vc2      (o_tr_vc2),
    .o_rx_h_tx_l   (o_rx_h_tx_l),
    .o_rx_h_tx_l_b (o_rx_h_tx_l_b)
  );

  assign pins = {o_mixer_en, o_shdn_rx_lna, o_shdn_tx_lna,
                 o_tr_vc1, o_tr_vc1_b, o_tr_vc2, o_rx_h_tx_l, o_rx_h_tx_l_b};

  always #5 i_sys_clk = ~i_sys_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an active sequence is described by its start edge and
  // target; expected pins follow from the elapsed edge count.
  bit         m_active, m_forced, m_done, m_err;
  int         m_n, m_start;
  logic [2:0] m_target, m_cur;
  logic [2:0] m_lna;
  logic [4:0] m_sw;

  function automatic logic [7:0] pat(input logic [2:0] m);
    case (m)
      3'd0:    pat = {1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b1};
      3'd1:    pat = {1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1};
      3'd2:    pat = {1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0};
      3'd3:    pat = {1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,1'b1};
      3'd4:    pat = {1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1};
      3'd5:    pat = {1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0};
      default: pat = 8'hxx;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    logic [7:0] p;
    p        = pat(3'd0);
    m_active = 1'b0;
    m_forced = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_cur    = 3'd0;
    m_target = 3'd0;
    m_lna    = p[7:5];
    m_sw     = p[4:0];
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pins"},  32'(pins), 32'h69);
    chk({tag, "_cur"},   32'(o_cur_mode), 32'd0);
    chk({tag, "_ready"}, 32'(o_req_ready), 32'd1);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
    chk({tag, "_done"},  32'(o_done), 32'd0);
    chk({tag, "_err"},   32'(o_err), 32'd0);
  endtask

  // One clock: apply inputs, check ready, advance model, check outputs
  task automatic step(input logic v, input logic [2:0] md, input logic f);
    logic [7:0] prev, tp;
    bit         idle_lp;
    int         k;
    i_req_valid = v;
    i_req_mode  = md;
    i_force_lp  = f;
    #1;
    chk("ready", 32'(o_req_ready), 32'(!m_active && !f));

    m_done  = 1'b0;
    m_err   = 1'b0;
    idle_lp = !m_active && (m_cur == 3'd0);
    if (f && !idle_lp && !(m_active && m_forced)) begin
      m_active = 1'b1; m_forced = 1'b1; m_start = m_n;
      m_target = 3'd0; m_lna = 3'b011;
    end else if (m_active) begin
      k  = m_n - m_start;
      tp = pat(m_target);
      if (k == int'(S)) m_sw = tp[4:0];
      if (k == int'(S + L)) begin
        m_lna = tp[7:5]; m_cur = m_target; m_done = 1'b1;
        m_active = 1'b0; m_forced = 1'b0;
      end
    end else if (v && !f) begin
      if (md > 3'd5) m_err = 1'b1;
      else if (md == m_cur) m_done = 1'b1;
      else begin
        m_active = 1'b1; m_forced = 1'b0; m_start = m_n;
        m_target = md; m_lna = 3'b011;
      end
    end
    m_n++;

    prev = pins;
    @(posedge i_sys_clk);
    #1;
    chk("pins", 32'(pins), 32'({m_lna, m_sw}));
    chk("cur_mode", 32'(o_cur_mode), 32'(m_cur));
    chk("done", 32'(o_done), 32'(m_done));
    chk("err", 32'(o_err), 32'(m_err));
    chk("busy", 32'(o_busy), 32'(m_active));
    chk("brk_before_make",
        32'(((prev[6:5] & ~pins[6:5]) != 2'b00) && (prev[4:0] != pins[4:0])), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    i_rst_b     = 1'b0;
    i_req_valid = 1'b0;
    i_req_mode  = 3'd0;
    i_force_lp  = 1'b0;
    m_n         = 0;
    m_start     = 0;
    model_reset();
    repeat (3) @(posedge i_sys_clk);
    #1;
    reset_checks("rst");
    #3 i_rst_b = 1'b1;
    @(posedge i_sys_clk);
    #1;

    // Request 010 from low_power; full break-before-make timeline
    step(1'b1, 3'd2, 1'b0);
    idle(S + L);
    chk("cur_after_010", 32'(o_cur_mode), 32'd2);

    // 100 held through, then 101 offered while busy and taken afterwards
    step(1'b1, 3'd4, 1'b0);
    for (int i = 0; i < int'(S + L + 1); i++) step(1'b1, 3'd5, 1'b0);
    idle(S + L);
    chk("cur_after_101", 32'(o_cur_mode), 32'd5);

    // Illegal modes
    step(1'b1, 3'd6, 1'b0);
    idle(1);
    step(1'b1, 3'd7, 1'b0);
    idle(1);

    // Back to 010, then request 101 and force low_power during GUARD_ON
    step(1'b1, 3'd2, 1'b0);
    idle(S + L);
    step(1'b1, 3'd5, 1'b0);
    idle(S);
    for (int i = 0; i < int'(S + L + 3); i++) step(1'b0, 3'd0, 1'b1);
    idle(1);
    chk("cur_after_force", 32'(o_cur_mode), 32'd0);

    // Same-mode request from 011
    step(1'b1, 3'd3, 1'b0);
    idle(S + L);
    step(1'b1, 3'd3, 1'b0);
    idle(2);

    // Force during GUARD_OFF, then force from idle in a non-LP mode
    step(1'b1, 3'd1, 1'b0);
    idle(2);
    for (int i = 0; i < int'(S + L + 2); i++) step(1'b1, 3'd4, 1'b1);
    step(1'b1, 3'd4, 1'b0);
    idle(S + L);
    for (int i = 0; i < int'(S + L + 2); i++) step(1'b0, 3'd0, 1'b1);

    // Asynchronous reset in the middle of a sequence
    step(1'b1, 3'd2, 1'b0);
    idle(S + 1);
    #2 i_rst_b = 1'b0;
    #1;
    reset_checks("mid_rst");
    model_reset();
    #1 i_rst_b = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 19) == 0));
    end
    idle(S + L + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
